// File: rtl/qsn_ctrl_pkg.sv
// Shared constants, FSM state type, select-set record and merge-mask helper
// for the quasi-cyclic shift network scheduler.
package qsn_ctrl_pkg;

    localparam int Z          = 85;
    localparam int SEL_W      = 7;
    localparam int COL_NUM    = 16;
    localparam int LAYER_NUM  = 8;
    localparam int NULL_SHIFT = 127;

    localparam int COL_W     = 4;
    localparam int LAYER_W   = 3;
    localparam int ADDR_W    = LAYER_W + COL_W;
    localparam int TBL_DEPTH = COL_NUM * LAYER_NUM;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL_NUM - 1);

    typedef enum logic [1:0] {INIT, IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [SEL_W-1:0] left;
        logic [SEL_W-1:0] right;
        logic [Z-2:0]     merge;
        logic             null_blk;
        logic [COL_W-1:0] col;
    } sel_set_t;

    localparam sel_set_t SEL_SET_RST = '{left: '0, right: '0, merge: '1, null_blk: 1'b0, col: '0};

    // Lane j takes the left net while it has not wrapped past the circulant edge.
    function automatic logic [Z-2:0] shift_to_merge(input logic [SEL_W-1:0] s);
        logic [Z-2:0] m;
        for (int j = 0; j < Z - 1; j++) begin
            m[j] = (j < (Z - int'(s)));
        end
        return m;
    endfunction

endpackage

// File: rtl/qsn_sel_decode.sv
// Combinational mapping of one circulant shift factor to the left/right/merge
// network selects; any code outside 0..Z-1 is treated as a zero submatrix.
module qsn_sel_decode
    import qsn_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0] shift,
    output logic [SEL_W-1:0] left_sel,
    output logic [SEL_W-1:0] right_sel,
    output logic [Z-2:0]     merge_sel,
    output logic             null_blk
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        left_sel  = '0;
        right_sel = '0;
        merge_sel = '1;
        null_blk  = 1'b0;
        if (int'(shift) >= Z) begin
            null_blk = 1'b1;
        end else begin
            left_sel  = shift;
            right_sel = (shift == '0) ? '0 : SEL_W'(Z - int'(shift));
            merge_sel = shift_to_merge(shift);
        end
    end

endmodule

// File: rtl/qsn_sched_ctrl.sv
// Layer sweep sequencer for the QSN datapath: shift table, sweep FSM and
// valid/ready select issue. Define QSN_SEL_REG_EN to add a registered skid stage.
module qsn_sched_ctrl
    import qsn_ctrl_pkg::*;
(
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [SEL_W-1:0]   cfg_shift,
    input  logic               start,
    input  logic [LAYER_W-1:0] layer_id,
    output logic               busy,
    output logic               done,
    output logic               sel_valid,
    input  logic               sel_ready,
    output logic [SEL_W-1:0]   left_sel,
    output logic [SEL_W-1:0]   right_sel,
    output logic [Z-2:0]       merge_sel,
    output logic [COL_W-1:0]   col_idx,
    output logic               null_blk
);

    logic [SEL_W-1:0]   tbl [TBL_DEPTH];
    state_t             state;
    logic [ADDR_W-1:0]  init_cnt;
    logic [LAYER_W-1:0] layer_q;
    logic [COL_W-1:0]   rd_col;
    logic [COL_W-1:0]   col_next;
    logic [SEL_W-1:0]   rd_shift;
    logic               rd_valid;
    logic               rd_ready;
    logic               tbl_we;
    logic [ADDR_W-1:0]  tbl_waddr;
    logic [SEL_W-1:0]   tbl_wdata;
    logic [SEL_W-1:0]   dec_left;
    logic [SEL_W-1:0]   dec_right;
    logic [Z-2:0]       dec_merge;
    logic               dec_null;
    sel_set_t           rd_set;
    sel_set_t           out_set;
    logic               out_valid;

    assign col_next = rd_col + COL_W'(1);

    // The init sweep owns the write port; configuration writes wait until it ends.
    always_comb begin
        tbl_we    = cfg_we;
        tbl_waddr = cfg_addr;
        tbl_wdata = cfg_shift;
        if (state == INIT) begin
            tbl_we    = 1'b1;
            tbl_waddr = init_cnt;
            tbl_wdata = SEL_W'(NULL_SHIFT);
        end
    end

    // NOTE: the table has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge sys_clk) begin
        if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= INIT;
            init_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            layer_q  <= '0;
            rd_col   <= '0;
            rd_shift <= '0;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    busy     <= 1'b1;
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == ADDR_W'(TBL_DEPTH - 1)) state <= IDLE;
                end
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        layer_q  <= layer_id;
                        rd_col   <= '0;
                        rd_shift <= tbl[{layer_id, COL_W'(0)}];
                        rd_valid <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (rd_valid && rd_ready) begin
                        if (rd_col == LAST_COL) begin
                            rd_valid <= 1'b0;
                        end else begin
                            rd_col   <= col_next;
                            rd_shift <= tbl[{layer_q, col_next}];
                        end
                    end
                    // Completion follows the datapath accept, not the table read.
                    if (sel_valid && sel_ready && col_idx == LAST_COL) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

    qsn_sel_decode u_dec (
        .shift     (rd_shift),
        .left_sel  (dec_left),
        .right_sel (dec_right),
        .merge_sel (dec_merge),
        .null_blk  (dec_null)
    );

    assign rd_set = '{left: dec_left, right: dec_right, merge: dec_merge,
                      null_blk: dec_null, col: rd_col};

`ifdef QSN_SEL_REG_EN
    sel_set_t skid_set;
    logic     skid_valid;

    // Two-entry skid: the spare slot catches the read issued while the output stalls.
    assign rd_ready = !skid_valid;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            out_set    <= SEL_SET_RST;
            skid_set   <= SEL_SET_RST;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || sel_ready) begin
            if (skid_valid) begin
                out_set    <= skid_set;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= rd_valid;
                if (rd_valid) out_set <= rd_set;
            end
        end else if (rd_valid && !skid_valid) begin
            skid_set   <= rd_set;
            skid_valid <= 1'b1;
        end
    end
`else
    assign rd_ready  = sel_ready;
    assign out_set   = rd_set;
    assign out_valid = rd_valid;
`endif

    assign sel_valid = out_valid;
    assign left_sel  = out_set.left;
    assign right_sel = out_set.right;
    assign merge_sel = out_set.merge;
    assign null_blk  = out_set.null_blk;
    assign col_idx   = out_set.col;

endmodule

// File: tb/tb_qsn_sched_ctrl.sv
// Directed self-checking bench for qsn_sched_ctrl: init sweep, select mapping,
// handshake stalls, ignored starts and mid-sweep reset.
module tb_qsn_sched_ctrl;

`ifdef QSN_SEL_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [83:0] M_ALL = {84{1'b1}};
    localparam logic [83:0] M_S5  = {4'b0000, {80{1'b1}}};
    localparam logic [83:0] M_S84 = 84'd1;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [6:0]  cfg_addr = '0;
    logic [6:0]  cfg_shift = '0;
    logic        start = 1'b0;
    logic [2:0]  layer_id = '0;
    logic        busy;
    logic        done;
    logic        sel_valid;
    logic        sel_ready = 1'b0;
    logic [6:0]  left_sel;
    logic [6:0]  right_sel;
    logic [83:0] merge_sel;
    logic [3:0]  col_idx;
    logic        null_blk;

    int errors = 0;
    int checks = 0;

    logic [6:0]  acc_left  [16];
    logic [6:0]  acc_right [16];
    logic [83:0] acc_merge [16];
    logic        acc_null  [16];
    logic [3:0]  acc_col   [16];
    int n_acc, done_cnt, done_at, first_lat, max_streak, hold_err, n_stall;

    qsn_sched_ctrl dut (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_shift (cfg_shift),
        .start     (start),
        .layer_id  (layer_id),
        .busy      (busy),
        .done      (done),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .left_sel  (left_sel),
        .right_sel (right_sel),
        .merge_sel (merge_sel),
        .col_idx   (col_idx),
        .null_blk  (null_blk)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic count_init(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    task automatic cfg_write(input logic [6:0] addr, input logic [6:0] val);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_shift = val;
        tick();
        cfg_we = 1'b0;
    endtask

    // Runs one sweep; stall applies ready pattern 1,0,0,1; inject pulses start mid-run and in DONE.
    task automatic sweep(input logic [2:0] lay, input bit stall, input bit inject);
        logic [101:0] h;
        bit hold_pend;
        int streak, after_done;
        n_acc = 0; done_cnt = 0; done_at = -1; first_lat = -1; max_streak = 0;
        hold_err = 0; n_stall = 0; streak = 0; after_done = 0; hold_pend = 0; h = '0;
        layer_id = lay;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 200 && after_done < 2; k++) begin
            sel_ready = stall ? ((k % 4 == 1) || (k % 4 == 0)) : 1'b1;
            if (hold_pend && ({left_sel, right_sel, merge_sel, null_blk, col_idx} !== h)) hold_err++;
            hold_pend = 0;
            if (sel_valid) begin
                streak++;
                if (first_lat < 0) first_lat = k;
                if (streak > max_streak) max_streak = streak;
            end else begin
                streak = 0;
            end
            if (done) begin
                done_cnt++;
                done_at = n_acc;
            end
            if (done_cnt > 0) after_done++;
            if (sel_valid && sel_ready) begin
                if (n_acc < 16) begin
                    acc_left[n_acc]  = left_sel;
                    acc_right[n_acc] = right_sel;
                    acc_merge[n_acc] = merge_sel;
                    acc_null[n_acc]  = null_blk;
                    acc_col[n_acc]   = col_idx;
                end
                n_acc++;
            end else if (sel_valid) begin
                n_stall++;
                h = {left_sel, right_sel, merge_sel, null_blk, col_idx};
                hold_pend = 1;
            end
            start    = inject && (k == 5 || done);
            layer_id = lay + 3'd1;
            tick();
        end
        start     = 1'b0;
        sel_ready = 1'b0;
    endtask

    function automatic int col_errors();
        int bad = 0;
        for (int i = 0; i < 16; i++) if (acc_col[i] !== 4'(i)) bad++;
        return bad;
    endfunction

    function automatic logic [15:0] null_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = acc_null[i];
        return v;
    endfunction

    initial begin
        int cnt;
        bool_found: begin end
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", sel_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_left", left_sel, 7'd0);
        check("rst_right", right_sel, 7'd0);
        check("rst_merge", merge_sel, M_ALL);
        check("rst_null", null_blk, 1'b0);

        rstn = 1'b1;
        count_init(cnt);
        check("init_busy_cycles", cnt, 128);

        // Cleared table: every column of layer 0 is a zero submatrix.
        sweep(3'd0, 1'b0, 1'b0);
        check("l0_latency", first_lat, LAT);
        check("l0_accepts", n_acc, 16);
        check("l0_null_all", null_vec(), 16'hFFFF);
        check("l0_col_order", col_errors(), 0);
        check("l0_done_at", done_at, 16);
        check("l0_done_pulse", done_cnt, 1);
        check("l0_streak", max_streak, 16);

        cfg_write(7'h20, 7'd5);
        cfg_write(7'h21, 7'd0);
        cfg_write(7'h22, 7'd84);
        cfg_write(7'h23, 7'd100);

        sweep(3'd2, 1'b0, 1'b0);
        check("l2_c0_left", acc_left[0], 7'd5);
        check("l2_c0_right", acc_right[0], 7'd80);
        check("l2_c0_merge", acc_merge[0], M_S5);
        check("l2_c0_null", acc_null[0], 1'b0);
        check("l2_c1_left", acc_left[1], 7'd0);
        check("l2_c1_right", acc_right[1], 7'd0);
        check("l2_c1_merge", acc_merge[1], M_ALL);
        check("l2_c1_null", acc_null[1], 1'b0);
        check("l2_c2_left", acc_left[2], 7'd84);
        check("l2_c2_right", acc_right[2], 7'd1);
        check("l2_c2_merge", acc_merge[2], M_S84);
        check("l2_c3_oor_null", acc_null[3], 1'b1);
        check("l2_c3_oor_left", acc_left[3], 7'd0);
        check("l2_c3_oor_merge", acc_merge[3], M_ALL);
        check("l2_c4_null", acc_null[4], 1'b1);
        check("l2_streak", max_streak, 16);

        sweep(3'd2, 1'b1, 1'b0);
        check("stall_accepts", n_acc, 16);
        check("stall_seen", n_stall > 0, 1'b1);
        check("stall_hold", hold_err, 0);
        check("stall_col_order", col_errors(), 0);
        check("stall_c0_left", acc_left[0], 7'd5);
        check("stall_c2_right", acc_right[2], 7'd1);
        check("stall_done_at", done_at, 16);
        check("stall_done_pulse", done_cnt, 1);

        sweep(3'd2, 1'b0, 1'b1);
        check("inj_accepts", n_acc, 16);
        check("inj_c0_left", acc_left[0], 7'd5);
        check("inj_c2_merge", acc_merge[2], M_S84);
        check("inj_c3_null", acc_null[3], 1'b1);
        check("inj_col_order", col_errors(), 0);
        check("inj_done_at", done_at, 16);
        check("inj_idle_busy", busy, 1'b0);
        check("inj_idle_valid", sel_valid, 1'b0);

        // Abort a sweep at column 7 with an asynchronous reset.
        cnt = 0;
        layer_id  = 3'd2;
        sel_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sel_valid && col_idx == 4'd7) begin
                cnt = 1;
                break;
            end
            tick();
        end
        check("abort_reached_col7", cnt, 1);
        #2 rstn = 1'b0;
        #1;
        check("abort_valid", sel_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_col", col_idx, 4'd0);
        check("abort_left", left_sel, 7'd0);
        check("abort_merge", merge_sel, M_ALL);
        sel_ready = 1'b0;
        tick();
        rstn = 1'b1;
        count_init(cnt);
        check("reinit_busy_cycles", cnt, 128);

        sweep(3'd2, 1'b0, 1'b0);
        check("reinit_cleared", null_vec(), 16'hFFFF);
        check("reinit_done_at", done_at, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
